// File: rtl/bist_pkg.sv
// Shared types and constants for the test-per-scan BIST controller.
// Holds the FSM encoding, LFSR tap mask and default polynomials.
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_e;

    localparam int CUT_PI_W = 5;
    localparam int CUT_PO_W = 9;
    localparam int MISR_W   = 16;

    // Feedback taps at bits 0, 2, 3 and 5
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;
    localparam logic [15:0] DEF_SEED      = 16'hACE1;
    localparam logic [15:0] DEF_MISR_POLY = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {^(v & LFSR_TAPS), v[15:1]};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Galois-style multiple-input signature register.
// clear has priority over en; the register holds when neither is set.
module bist_misr #(
    parameter int          W    = 16,
    parameter logic [W-1:0] POLY = '1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] misr_q;
    logic [W-1:0] misr_d;

    always_comb begin
        misr_d = misr_q;
        if (clear_i) begin
            misr_d = '0;
        end else if (en_i) begin
            misr_d = (misr_q >> 1) ^ (misr_q[0] ? POLY : '0) ^ data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misr_q <= '0;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign sig_o = misr_q;

endmodule

// File: rtl/bist_scan_ctrl.sv
// Test-per-scan BIST controller: LFSR drives the CUT scan chain and inputs,
// a MISR compacts scan_out and CUT outputs, and the result is checked at DONE.
module bist_scan_ctrl
    import bist_pkg::*;
#(
    parameter int          CHAIN_LEN = 12,
    parameter int          PATTERNS  = 256,
    parameter logic [15:0] LFSR_SEED = DEF_SEED,
    parameter logic [15:0] MISR_POLY = DEF_MISR_POLY,
    parameter logic [15:0] GOLDEN    = 16'h0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [MISR_W-1:0]   signature,
    output logic                cut_reset,
    output logic                scan_en,
    output logic                scan_in,
    input  logic                scan_out,
    output logic [CUT_PI_W-1:0] cut_pi,
    input  logic [CUT_PO_W-1:0] cut_po
);

    state_e                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [7:0]            bit_cnt_q, bit_cnt_d;
    logic [15:0]           pat_cnt_q, pat_cnt_d;
    logic [CUT_PI_W-1:0]   cut_pi_q, cut_pi_d;

    logic                  misr_en;
    logic                  misr_clr;
    logic [MISR_W-1:0]     misr_data;

    logic last_bit;
    logic last_pat;

    assign last_bit = (bit_cnt_q == 8'(CHAIN_LEN - 1));
    assign last_pat = (pat_cnt_q == 16'(PATTERNS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            lfsr_q    <= LFSR_SEED;
            bit_cnt_q <= '0;
            pat_cnt_q <= '0;
            cut_pi_q  <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            bit_cnt_q <= bit_cnt_d;
            pat_cnt_q <= pat_cnt_d;
            cut_pi_q  <= cut_pi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        bit_cnt_d = bit_cnt_q;
        pat_cnt_d = pat_cnt_q;
        cut_pi_d  = cut_pi_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                lfsr_d    = LFSR_SEED;
                bit_cnt_d = '0;
                pat_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (last_bit) begin
                    bit_cnt_d = '0;
                    cut_pi_d  = lfsr_q[15:11];
                    state_d   = S_CAPTURE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                // Cleared on the last pattern so the counter never wraps
                if (last_pat) begin
                    pat_cnt_d = '0;
                    state_d   = S_FLUSH;
                end else begin
                    pat_cnt_d = pat_cnt_q + 16'd1;
                    state_d   = S_SHIFT;
                end
            end
            S_FLUSH: begin
                if (last_bit) begin
                    bit_cnt_d = '0;
                    state_d   = S_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        cut_reset = 1'b0;
        scan_en   = 1'b0;
        scan_in   = 1'b0;
        misr_en   = 1'b0;
        misr_clr  = 1'b0;
        misr_data = '0;
        unique case (state_q)
            S_INIT: begin
                busy      = 1'b1;
                cut_reset = 1'b1;
                misr_clr  = 1'b1;
            end
            S_SHIFT: begin
                busy      = 1'b1;
                scan_en   = 1'b1;
                scan_in   = lfsr_q[0];
                misr_en   = 1'b1;
                misr_data = {{(MISR_W-1){1'b0}}, scan_out};
            end
            S_CAPTURE: begin
                busy      = 1'b1;
                misr_en   = 1'b1;
                misr_data = {{(MISR_W-CUT_PO_W){1'b0}}, cut_po};
            end
            S_FLUSH: begin
                busy      = 1'b1;
                scan_en   = 1'b1;
                misr_en   = 1'b1;
                misr_data = {{(MISR_W-1){1'b0}}, scan_out};
            end
            S_DONE: begin
                done = 1'b1;
                pass = (signature == GOLDEN);
            end
            default: ;
        endcase
    end

    bist_misr #(
        .W    (MISR_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk_i   (clock),
        .rst_ni  (reset),
        .en_i    (misr_en),
        .clear_i (misr_clr),
        .data_i  (misr_data),
        .sig_o   (signature)
    );

    assign cut_pi = cut_pi_q;

endmodule
